// File: rtl/pad_ctrl_pkg.sv
// Shared definitions for the pad input conditioning block: cfg bit positions and irq modes.
package pad_ctrl_pkg;

  localparam int unsigned CFG_PULL_EN = 0;
  localparam int unsigned CFG_FILT_EN = 1;
  localparam int unsigned CFG_IRQ_LSB = 2;

  typedef enum logic [1:0] {
    IRQ_OFF  = 2'b00,
    IRQ_RISE = 2'b01,
    IRQ_FALL = 2'b10,
    IRQ_BOTH = 2'b11
  } irq_mode_e;

  function automatic logic irq_hit(irq_mode_e mode, logic rise, logic fall);
    logic hit;
    unique case (mode)
      IRQ_RISE: hit = rise;
      IRQ_FALL: hit = fall;
      IRQ_BOTH: hit = rise | fall;
      default:  hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/pad_in_chan.sv
// One pad input channel: synchroniser, glitch filter, edge events and sticky pending flag.
module pad_in_chan
  import pad_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_W      = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              warm_i,
  input  logic              filt_en_i,
  input  irq_mode_e         irq_mode_i,
  input  logic [FILT_W-1:0] filt_thresh_i,
  input  logic              raw_i,
  input  logic              irq_clr_i,
  output logic              pad_in_o,
  output logic              rise_evt_o,
  output logic              fall_evt_o,
  output logic              irq_pend_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic                   pad_in_q, pad_in_d;
  logic [FILT_W-1:0]      cnt_q, cnt_d;
  logic                   rise_q, rise_d, fall_q, fall_d;
  logic                   pend_q, pend_d;
  logic [FILT_W-1:0]      thr_eff;
  logic [FILT_W:0]        cnt_inc;

  assign sync    = sync_q[SYNC_STAGES-1];
  assign cnt_inc = {1'b0, cnt_q} + 1'b1;

  // Threshold of zero, or filter disabled, both mean single-cycle acceptance.
  always_comb begin
    thr_eff = FILT_W'(1);
    if (filt_en_i && (filt_thresh_i != '0)) thr_eff = filt_thresh_i;
  end

  always_comb begin
    pad_in_d = pad_in_q;
    cnt_d    = cnt_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (warm_i) begin
      pad_in_d = sync;
      cnt_d    = '0;
    end else if (sync == pad_in_q) begin
      cnt_d = '0;
    end else if (cnt_inc >= {1'b0, thr_eff}) begin
      pad_in_d = sync;
      cnt_d    = '0;
      rise_d   = sync;
      fall_d   = ~sync;
    end else begin
      cnt_d = cnt_inc[FILT_W-1:0];
    end
  end

  // Set has priority over clear so an event coinciding with a clear is never lost.
  always_comb begin
    pend_d = pend_q;
    if (irq_hit(irq_mode_i, rise_q, fall_q)) begin
      pend_d = 1'b1;
    end else if (irq_clr_i) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q   <= '0;
      pad_in_q <= 1'b0;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], raw_i};
      pad_in_q <= pad_in_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      pend_q   <= pend_d;
    end
  end

  assign pad_in_o   = pad_in_q;
  assign rise_evt_o = rise_q;
  assign fall_evt_o = fall_q;
  assign irq_pend_o = pend_q;

endmodule

// File: rtl/pad_in_ctrl.sv
// Pad input conditioning and pad-cell control for N_PADS channels with shared warm-up.
module pad_in_ctrl
  import pad_ctrl_pkg::*;
#(
  parameter int unsigned N_PADS      = 48,
  parameter int unsigned CFG_W       = 6,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_W      = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [N_PADS-1:0][CFG_W-1:0] pad_cfg_i,
  input  logic [FILT_W-1:0]            filt_thresh_i,
  input  logic [N_PADS-1:0]            pad_raw_i,
  input  logic [N_PADS-1:0]            oe_i,
  input  logic [N_PADS-1:0]            out_i,
  output logic [N_PADS-1:0]            pad_oen_o,
  output logic [N_PADS-1:0]            pad_i_o,
  output logic [N_PADS-1:0]            pad_pen_o,
  output logic [N_PADS-1:0]            pad_in_o,
  output logic [N_PADS-1:0]            rise_evt_o,
  output logic [N_PADS-1:0]            fall_evt_o,
  input  logic [N_PADS-1:0]            irq_clr_i,
  output logic [N_PADS-1:0]            irq_pend_o,
  output logic                         irq_o
);

  localparam int unsigned WarmEdges = SYNC_STAGES + 1;
  localparam int unsigned WarmW     = $clog2(WarmEdges + 1);

  logic [WarmW-1:0] warm_q;
  logic             warm;
  logic             unused_cfg;

  // Warm-up spans the first SYNC_STAGES+1 edges so power-up levels load without events.
  assign warm = (warm_q != WarmW'(WarmEdges));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      warm_q <= '0;
    end else if (warm) begin
      warm_q <= warm_q + 1'b1;
    end
  end

  for (genvar k = 0; k < N_PADS; k++) begin : g_chan
    pad_in_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_W      (FILT_W)
    ) u_chan (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .warm_i        (warm),
      .filt_en_i     (pad_cfg_i[k][CFG_FILT_EN]),
      .irq_mode_i    (irq_mode_e'(pad_cfg_i[k][CFG_IRQ_LSB +: 2])),
      .filt_thresh_i (filt_thresh_i),
      .raw_i         (pad_raw_i[k]),
      .irq_clr_i     (irq_clr_i[k]),
      .pad_in_o      (pad_in_o[k]),
      .rise_evt_o    (rise_evt_o[k]),
      .fall_evt_o    (fall_evt_o[k]),
      .irq_pend_o    (irq_pend_o[k])
    );
  end

  always_comb begin
    pad_pen_o = '0;
    for (int k = 0; k < N_PADS; k++) pad_pen_o[k] = ~pad_cfg_i[k][CFG_PULL_EN];
  end

  assign pad_oen_o  = ~oe_i;
  assign pad_i_o    = out_i;
  assign irq_o      = |irq_pend_o;
  // Reserved cfg bits are intentionally ignored.
  assign unused_cfg = ^pad_cfg_i;

endmodule

// File: tb/tb_pad_in_ctrl.sv
// Self-checking bench for pad_in_ctrl: behavioural model compared every cycle plus literal pins.
module tb_pad_in_ctrl;

  localparam int N  = 48;
  localparam int CW = 6;
  localparam int S  = 2;
  localparam int FW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [N-1:0][CW-1:0] pad_cfg = '0;
  logic [FW-1:0] thresh = '0;
  logic [N-1:0] raw = '0, oe = '0, out = '0, clr = '0;
  logic [N-1:0] pad_oen, pad_i, pad_pen, pad_in, rise_evt, fall_evt, irq_pend;
  logic irq;

  pad_in_ctrl #(
    .N_PADS      (N),
    .CFG_W       (CW),
    .SYNC_STAGES (S),
    .FILT_W      (FW)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .pad_cfg_i     (pad_cfg),
    .filt_thresh_i (thresh),
    .pad_raw_i     (raw),
    .oe_i          (oe),
    .out_i         (out),
    .pad_oen_o     (pad_oen),
    .pad_i_o       (pad_i),
    .pad_pen_o     (pad_pen),
    .pad_in_o      (pad_in),
    .rise_evt_o    (rise_evt),
    .fall_evt_o    (fall_evt),
    .irq_clr_i     (clr),
    .irq_pend_o    (irq_pend),
    .irq_o         (irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Model state: history of raw samples, edge count since reset, accepted levels, run lengths.
  logic [N-1:0] rawq[$];
  int           edges;
  logic [N-1:0] m_lvl, m_rise, m_fall, m_pend;
  int           run[N];

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    rawq.delete();
    edges  = 0;
    m_lvl  = '0;
    m_rise = '0;
    m_fall = '0;
    m_pend = '0;
    for (int k = 0; k < N; k++) run[k] = 0;
  endtask

  task automatic model_step();
    logic [N-1:0] seen;
    logic [1:0]   mode;
    int           t;
    if (!rst_n) begin
      model_reset();
      return;
    end
    edges++;
    rawq.push_front(raw);
    if (rawq.size() > S + 1) void'(rawq.pop_back());
    // The filter acts on the raw value sampled S edges earlier.
    seen = (rawq.size() > S) ? rawq[S] : '0;
    for (int k = 0; k < N; k++) begin
      mode = pad_cfg[k][3:2];
      if ((m_rise[k] && mode[0]) || (m_fall[k] && mode[1])) m_pend[k] = 1'b1;
      else if (clr[k]) m_pend[k] = 1'b0;
    end
    m_rise = '0;
    m_fall = '0;
    if (edges <= S + 1) begin
      m_lvl = seen;
      for (int k = 0; k < N; k++) run[k] = 0;
    end else begin
      for (int k = 0; k < N; k++) begin
        t = (pad_cfg[k][1] && thresh != 0) ? int'(thresh) : 1;
        if (seen[k] == m_lvl[k]) begin
          run[k] = 0;
        end else begin
          run[k]++;
          if (run[k] >= t) begin
            m_lvl[k] = seen[k];
            m_rise[k] = seen[k];
            m_fall[k] = ~seen[k];
            run[k] = 0;
          end
        end
      end
    end
  endtask

  task automatic compare();
    logic [N-1:0] exp_pen;
    for (int k = 0; k < N; k++) exp_pen[k] = ~pad_cfg[k][0];
    chk("pad_in", pad_in, m_lvl);
    chk("rise_evt", rise_evt, m_rise);
    chk("fall_evt", fall_evt, m_fall);
    chk("irq_pend", irq_pend, m_pend);
    chk("irq", N'(irq), N'(|m_pend));
    chk("pad_oen", pad_oen, ~oe);
    chk("pad_i", pad_i, out);
    chk("pad_pen", pad_pen, exp_pen);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    // Reset with pad 0 already high: it must load without an event.
    pad_cfg[0] = 6'b001100;
    raw[0] = 1'b1;
    oe  = 48'h0000_FFFF_0000;
    out = 48'h1234_5678_9ABC;
    #1 rst_n = 1'b0;
    model_reset();
    #1 compare();
    chk("lit_reset_pad_in", pad_in, '0);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(2);
    chk("lit_warm_pad_in0_low", N'(pad_in[0]), N'(0));
    cycle();
    chk("lit_warm_pad_in0_high", N'(pad_in[0]), N'(1));
    cycles(3);
    chk("lit_warm_no_pend", irq_pend, '0);

    // Filter off, rise irq on pad 3.
    pad_cfg[3] = 6'b000100;
    raw[3] = 1'b1;
    cycles(2);
    chk("lit_p3_not_yet", N'(pad_in[3]), N'(0));
    cycle();
    chk("lit_p3_rise", N'(rise_evt[3]), N'(1));
    cycle();
    chk("lit_p3_rise_gone", N'(rise_evt[3]), N'(0));
    chk("lit_p3_pend", N'(irq_pend[3]), N'(1));
    chk("lit_p3_irq", N'(irq), N'(1));
    clr[3] = 1'b1;
    cycle();
    clr[3] = 1'b0;
    chk("lit_p3_cleared", N'(irq_pend[3]), N'(0));

    // Filter on, threshold 4: a 3-cycle glitch is rejected, a sustained level accepted.
    pad_cfg[5] = 6'b000110;
    thresh = 8'd4;
    raw[5] = 1'b1;
    cycles(3);
    raw[5] = 1'b0;
    cycles(6);
    chk("lit_p5_glitch", N'(pad_in[5]), N'(0));
    raw[5] = 1'b1;
    cycles(5);
    chk("lit_p5_before", N'(pad_in[5]), N'(0));
    cycle();
    chk("lit_p5_accept", N'(pad_in[5]), N'(1));
    chk("lit_p5_rise", N'(rise_evt[5]), N'(1));
    cycles(2);
    clr = '1;
    cycle();
    clr = '0;

    // Both edges on pad 7, clear coinciding with a set.
    pad_cfg[7] = 6'b001100;
    thresh = 8'd0;
    raw[7] = 1'b1;
    cycles(3);
    chk("lit_p7_rise", N'(rise_evt[7]), N'(1));
    clr[7] = 1'b1;
    cycle();
    clr[7] = 1'b0;
    chk("lit_p7_set_wins", N'(irq_pend[7]), N'(1));
    raw[7] = 1'b0;
    cycles(3);
    chk("lit_p7_fall", N'(fall_evt[7]), N'(1));
    cycle();
    clr[7] = 1'b1;
    cycle();
    clr[7] = 1'b0;
    chk("lit_p7_clear", N'(irq_pend[7]), N'(0));
    chk("lit_irq_low", N'(irq), N'(0));

    // Pad 9 controls, and threshold 0 with filter enabled acts as T=1.
    pad_cfg[9] = 6'b000011;
    oe[9] = 1'b1;
    out[9] = 1'b0;
    out[20] = 1'b1;
    raw[9] = 1'b1;
    cycles(3);
    chk("lit_p9_oen", N'(pad_oen[9]), N'(0));
    chk("lit_p9_i", N'(pad_i[9]), N'(0));
    chk("lit_p9_pen", N'(pad_pen[9]), N'(0));
    chk("lit_p9_t1", N'(pad_in[9]), N'(1));

    // Reset in the middle of a filter count on pad 11.
    pad_cfg[11] = 6'b000110;
    thresh = 8'd4;
    raw[11] = 1'b1;
    cycles(4);
    rst_n = 1'b0;
    model_reset();
    #1 compare();
    chk("lit_rst_pad_in", pad_in, '0);
    chk("lit_rst_irq", N'(irq), N'(0));
    cycles(2);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(2);
    chk("lit_rewarm_low", pad_in, '0);
    cycle();
    chk("lit_rewarm_load", pad_in, raw);
    cycles(4);
    chk("lit_rewarm_no_evt", rise_evt, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
